sva_thread_sched: RTL



---
 rtl/sva_sched_pkg.sv | 25 ++
 rtl/sva_thread_sched_if.sv | 27 ++
 rtl/sva_slot_table.sv | 28 ++
 rtl/sva_thread_sched.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/sva_sched_pkg.sv
// rtl/sva_sched_pkg.sv - shared types and widths for the SVA thread scheduler
package sva_sched_pkg;

  localparam int STATE_W      = 8;
  localparam int TIMER_WIDTH  = 16;
  localparam int SLOT_NUM_DEF = 8;

  // Every new thread enters the assertion FSM here.
  localparam logic [STATE_W-1:0] START_STATE = '0;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ISSUE       = 3'd1,
    WAIT        = 3'd2,
    SPAWN_ISSUE = 3'd3,
    SPAWN_WAIT  = 3'd4,
    COMMIT      = 3'd5
  } sched_state_t;

  typedef struct packed {
    logic signed [STATE_W-1:0]     state;
    logic        [TIMER_WIDTH-1:0] start_period;
  } slot_t;

endpackage

// File: rtl/sva_thread_sched_if.sv
// rtl/sva_thread_sched_if.sv - scheduler <-> next-state evaluator request/response bundle
interface sva_thread_sched_if;
  import sva_sched_pkg::*;

  logic                   req_valid;
  logic                   req_ready;
  logic [STATE_W-1:0]     req_state;
  logic [TIMER_WIDTH-1:0] req_period;
  logic                   rsp_valid;
  logic                   rsp_active;
  logic [STATE_W-1:0]     rsp_state;
  logic                   rsp_succ;
  logic                   rsp_fail;

  // Scheduler side issues requests and consumes responses.
  modport master (
    output req_valid, req_state, req_period,
    input  req_ready, rsp_valid, rsp_active, rsp_state, rsp_succ, rsp_fail
  );

  // Evaluator side.
  modport slave (
    input  req_valid, req_state, req_period,
    output req_ready, rsp_valid, rsp_active, rsp_state, rsp_succ, rsp_fail
  );

endinterface

// File: rtl/sva_slot_table.sv
// rtl/sva_slot_table.sv - thread slot register file, async read / sync write
module sva_slot_table
  import sva_sched_pkg::*;
#(
  parameter int SLOT_NUM = SLOT_NUM_DEF,
  parameter int AW       = $clog2(SLOT_NUM)
) (
  input  logic          clk,
  input  logic [AW-1:0] rd_idx,
  output slot_t         rd_data,
  input  logic          we,
  input  logic [AW-1:0] wr_idx,
  input  slot_t         wr_data
);

  // Contents are only meaningful below live_cnt, so no reset is needed.
  slot_t mem_q [SLOT_NUM];

  // Single write port used by in-place compaction and spawn append.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/sva_thread_sched.sv
// rtl/sva_thread_sched.sv - sweeps live SVA threads through the evaluator and spawns one per tick
module sva_thread_sched
  import sva_sched_pkg::*;
#(
  parameter int SLOT_NUM = SLOT_NUM_DEF
) (
  input  logic                           sys_clk,
  input  logic                           sys_rst_n,
  input  logic                           enable,
  input  logic                           tick,
  input  logic [TIMER_WIDTH-1:0]         period,
  sva_thread_sched_if.master             eval,
  output logic                           busy,
  output logic [$clog2(SLOT_NUM+1)-1:0]  live_cnt,
  output logic                           succ_pulse,
  output logic                           fail_pulse,
  output logic [TIMER_WIDTH-1:0]         event_period,
  output logic                           overflow,
  output logic                           overrun
);

  localparam int CNT_W = $clog2(SLOT_NUM+1);
  localparam int AW    = $clog2(SLOT_NUM);

  sched_state_t           state_q, state_d;
  logic [CNT_W-1:0]       rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0]       wr_idx_q, wr_idx_d;
  logic [CNT_W-1:0]       live_cnt_q, live_cnt_d;
  logic [TIMER_WIDTH-1:0] spawn_period_q, spawn_period_d;
  logic [TIMER_WIDTH-1:0] event_period_q, event_period_d;
  logic                   busy_q, busy_d;
  logic                   succ_q, succ_d;
  logic                   fail_q, fail_d;
  logic                   overflow_q, overflow_d;
  logic                   overrun_q, overrun_d;

  logic                   tick_acc;
  logic                   spawn_ph;
  logic                   rsp_take;
  logic                   we;
  slot_t                  rd_slot;
  slot_t                  wr_slot;
  logic [STATE_W-1:0]     cur_state;
  logic [TIMER_WIDTH-1:0] cur_period;

  sva_slot_table #(.SLOT_NUM(SLOT_NUM), .AW(AW)) u_table (
    .clk     (sys_clk),
    .rd_idx  (rd_idx_q[AW-1:0]),
    .rd_data (rd_slot),
    .we      (we),
    .wr_idx  (wr_idx_q[AW-1:0]),
    .wr_data (wr_slot)
  );

  assign tick_acc   = tick && enable;
  assign spawn_ph   = (state_q == SPAWN_ISSUE) || (state_q == SPAWN_WAIT);
  assign rsp_take   = eval.rsp_valid && ((state_q == WAIT) || (state_q == SPAWN_WAIT));
  // The thread under evaluation stays selected from issue through its response.
  assign cur_state  = spawn_ph ? START_STATE : rd_slot.state;
  assign cur_period = spawn_ph ? spawn_period_q : rd_slot.start_period;
  assign wr_slot    = {eval.rsp_state, cur_period};

  assign eval.req_valid  = (state_q == ISSUE) || (state_q == SPAWN_ISSUE);
  assign eval.req_state  = cur_state;
  assign eval.req_period = cur_period;

  // Sweep sequencing, compaction writes, event pulses and sticky health flags.
  always_comb begin
    state_d        = state_q;
    rd_idx_d       = rd_idx_q;
    wr_idx_d       = wr_idx_q;
    live_cnt_d     = live_cnt_q;
    spawn_period_d = spawn_period_q;
    event_period_d = event_period_q;
    busy_d         = busy_q;
    succ_d         = 1'b0;
    fail_d         = 1'b0;
    overflow_d     = overflow_q;
    overrun_d      = overrun_q;
    we             = 1'b0;

    if (rsp_take) begin
      succ_d = eval.rsp_succ;
      fail_d = eval.rsp_fail;
      if (eval.rsp_succ || eval.rsp_fail) begin
        event_period_d = cur_period;
      end
    end

    if (tick_acc && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (tick_acc) begin
          spawn_period_d = period;
          rd_idx_d       = '0;
          wr_idx_d       = '0;
          busy_d         = 1'b1;
          state_d        = (live_cnt_q != '0) ? ISSUE : SPAWN_ISSUE;
        end
      end
      ISSUE: begin
        if (eval.req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (eval.rsp_valid) begin
          if (eval.rsp_active) begin
            we       = 1'b1;
            wr_idx_d = wr_idx_q + 1'b1;
          end
          rd_idx_d = rd_idx_q + 1'b1;
          state_d  = ((rd_idx_q + 1'b1) < live_cnt_q) ? ISSUE : SPAWN_ISSUE;
        end
      end
      SPAWN_ISSUE: begin
        if (eval.req_ready) state_d = SPAWN_WAIT;
      end
      SPAWN_WAIT: begin
        if (eval.rsp_valid) begin
          if (eval.rsp_active) begin
            if (wr_idx_q < CNT_W'(SLOT_NUM)) begin
              we       = 1'b1;
              wr_idx_d = wr_idx_q + 1'b1;
            end else begin
              overflow_d = 1'b1;
            end
          end
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        live_cnt_d = wr_idx_q;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops every thread and abandons any sweep.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q        <= IDLE;
      rd_idx_q       <= '0;
      wr_idx_q       <= '0;
      live_cnt_q     <= '0;
      spawn_period_q <= '0;
      event_period_q <= '0;
      busy_q         <= 1'b0;
      succ_q         <= 1'b0;
      fail_q         <= 1'b0;
      overflow_q     <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      rd_idx_q       <= rd_idx_d;
      wr_idx_q       <= wr_idx_d;
      live_cnt_q     <= live_cnt_d;
      spawn_period_q <= spawn_period_d;
      event_period_q <= event_period_d;
      busy_q         <= busy_d;
      succ_q         <= succ_d;
      fail_q         <= fail_d;
      overflow_q     <= overflow_d;
      overrun_q      <= overrun_d;
    end
  end

  assign busy         = busy_q;
  assign live_cnt     = live_cnt_q;
  assign succ_pulse   = succ_q;
  assign fail_pulse   = fail_q;
  assign event_period = event_period_q;
  assign overflow     = overflow_q;
  assign overrun      = overrun_q;

endmodule
